// File: rtl/crc_32_stream_pkg.sv
// Shared constants, state encoding and the single-byte reflected CRC-32 step
// used by the streaming Ethernet FCS engine.
package crc_32_stream_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ACCUM = 2'd1;
    localparam state_t DONE  = 2'd2;

    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data_byte,
        input logic [31:0] poly
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_32_stream_fold.sv
// Combinational fold of one beat into the CRC register: kept bytes are
// applied in ascending index order, skipped bytes pass the value through.
module crc_32_fold
    import crc_32_stream_pkg::*;
#(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] POLY       = CRC32_POLY
) (
    input  logic [31:0]             crc_in,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [DATA_BYTES-1:0]   keep,
    output logic [31:0]             crc_out
);

    logic [31:0] chain;

    always_comb begin
        chain = crc_in;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (keep[i]) begin
                chain = crc32_byte(chain, data[8*i +: 8], POLY);
            end
        end
    end

    assign crc_out = chain;

endmodule

// File: rtl/crc_32_stream.sv
// Framed CRC-32 engine: FSM, handshake and result registers around the
// combinational fold; generate mode reports the FCS, check mode the residue.
module crc_32_stream
    import crc_32_stream_pkg::*;
#(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] POLY       = CRC32_POLY,
    parameter logic [31:0] INIT       = CRC32_INIT,
    parameter logic [31:0] XOR_OUT    = CRC32_XOR_OUT,
    parameter logic [31:0] RESIDUE    = CRC32_RESIDUE,
    parameter int          CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    check_en,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    output logic [31:0]             crc_out,
    output logic                    crc_valid,
    output logic                    crc_match,
    output logic [CNT_W-1:0]        byte_cnt
);

    state_t             state_q, state_d;
    logic [31:0]        crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic [31:0]        crc_out_q, crc_out_d;
    logic               crc_valid_q, crc_valid_d;
    logic               crc_match_q, crc_match_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;

    logic [31:0]        fold;
    logic [3:0]         pop;
    logic [CNT_W:0]     cnt_sum;
    logic [CNT_W-1:0]   cnt_sat;
    logic               accept;
    logic               mode_now;

    crc_32_fold #(
        .DATA_BYTES (DATA_BYTES),
        .POLY       (POLY)
    ) u_fold (
        .crc_in  (crc_q),
        .data    (s_data),
        .keep    (s_keep),
        .crc_out (fold)
    );

    assign s_ready = (state_q != DONE) & ~clr & ~rst;
    assign accept  = s_valid & s_ready;

    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            pop = pop + {3'd0, s_keep[i]};
        end
    end

    // Counter saturates at all-ones instead of wrapping.
    assign cnt_sum  = {1'b0, cnt_q} + {{(CNT_W-3){1'b0}}, pop};
    assign cnt_sat  = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    assign mode_now = (state_q == IDLE) ? check_en : mode_q;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        crc_out_d   = crc_out_q;
        crc_match_d = crc_match_q;
        byte_cnt_d  = byte_cnt_q;
        crc_valid_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            crc_d   = INIT;
            cnt_d   = '0;
        end else if (accept) begin
            mode_d = mode_now;
            if (s_last) begin
                state_d     = DONE;
                crc_d       = INIT;
                cnt_d       = '0;
                crc_out_d   = fold ^ XOR_OUT;
                crc_match_d = mode_now & (fold == RESIDUE);
                byte_cnt_d  = cnt_sat;
                crc_valid_d = 1'b1;
            end else begin
                state_d = ACCUM;
                crc_d   = fold;
                cnt_d   = cnt_sat;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            crc_out_q   <= '0;
            crc_valid_q <= 1'b0;
            crc_match_q <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
            crc_match_q <= crc_match_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign crc_out   = crc_out_q;
    assign crc_valid = crc_valid_q;
    assign crc_match = crc_match_q;
    assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_crc_32_stream.sv
// Bench for crc_32_stream: bit-serial frame model with per-cycle compare,
// plus directed frames with hand-computed results.
module tb_crc_32_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        check_en;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic [31:0] crc_out;
    logic        crc_valid;
    logic        crc_match;
    logic [15:0] byte_cnt;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;

    crc_32_stream #(.DATA_BYTES(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .check_en  (check_en),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_last    (s_last),
        .crc_out   (crc_out),
        .crc_valid (crc_valid),
        .crc_match (crc_match),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: textbook bit-at-a-time reflected LFSR over the whole frame.
    function automatic logic [31:0] ref_reg(input logic [7:0] q[$]);
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFFFFFF;
        foreach (q[n]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ q[n][b];
                r  = r >> 1;
                if (fb) r = r ^ 32'hEDB88320;
            end
        end
        return r;
    endfunction

    logic [7:0]  fq[$];
    bit          model_ok = 0;
    bit          in_done, in_frame, m_mode;
    int          m_cnt;
    logic [31:0] e_out;
    logic        e_valid, e_match;
    logic [15:0] e_cnt;

    always @(posedge clk) begin
        logic [31:0] r;
        if (rst) begin
            model_ok = 1;
            in_done  = 0;
            in_frame = 0;
            fq.delete();
            m_cnt    = 0;
            e_out    = 0;
            e_valid  = 0;
            e_match  = 0;
            e_cnt    = 0;
        end else begin
            e_valid = 0;
            if (in_done) begin
                in_done = 0;
            end else if (clr) begin
                in_frame = 0;
                fq.delete();
                m_cnt = 0;
            end else if (s_valid) begin
                if (!in_frame) m_mode = check_en;
                in_frame = 1;
                for (int i = 0; i < 4; i++) begin
                    if (s_keep[i]) begin
                        fq.push_back(s_data[8*i +: 8]);
                        if (m_cnt < 65535) m_cnt++;
                    end
                end
                if (s_last) begin
                    r        = ref_reg(fq);
                    e_out    = r ^ 32'hFFFFFFFF;
                    e_match  = m_mode && (r == 32'hDEBB20E3);
                    e_cnt    = 16'(m_cnt);
                    e_valid  = 1;
                    in_done  = 1;
                    in_frame = 0;
                    fq.delete();
                    m_cnt = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("s_ready", {31'd0, s_ready},
                {31'd0, !in_done && !clr && !rst});
            chk("crc_valid", {31'd0, crc_valid}, {31'd0, e_valid});
            chk("crc_out", crc_out, e_out);
            chk("crc_match", {31'd0, crc_match}, {31'd0, e_match});
            chk("byte_cnt", {16'd0, byte_cnt}, {16'd0, e_cnt});
            if (crc_valid) nvalid++;
        end
    end

    task automatic beat(input logic [31:0] d, input logic [3:0] k,
                        input logic l, output int waits);
        logic r;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        waits   = 0;
        forever begin
            @(negedge clk);
            r = s_ready;
            @(posedge clk);
            #1;
            if (r) break;
            waits++;
            if (waits > 20) begin
                errors++;
                $display("FAIL beat_timeout: waited %0d cycles", waits);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] c,
                                 input logic [15:0] n, input logic m);
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, crc_valid}, 32'd1);
        chk({name, "_crc"}, crc_out, c);
        chk({name, "_cnt"}, {16'd0, byte_cnt}, {16'd0, n});
        chk({name, "_match"}, {31'd0, crc_match}, {31'd0, m});
        @(posedge clk);
        #1;
    endtask

    task automatic std_frame(input int gaps);
        int w;
        beat(32'h34333231, 4'hF, 1'b0, w);
        if (gaps != 0) idle($urandom_range(0, 3));
        beat(32'h38373635, 4'hF, 1'b0, w);
        if (gaps != 0) idle($urandom_range(0, 3));
        beat(32'h00000039, 4'h1, 1'b1, w);
    endtask

    initial begin
        int w;
        int n0;
        logic [7:0] msg [9];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst = 1; clr = 0; check_en = 0;
        s_valid = 0; s_data = 0; s_keep = 0; s_last = 0;
        idle(3);
        rst = 0;
        @(negedge clk);
        chk("reset_crc_out", crc_out, 32'h0);
        chk("reset_cnt", {16'd0, byte_cnt}, 32'h0);
        chk("ready_after_reset", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        #1;

        // One byte per beat
        for (int i = 0; i < 9; i++)
            beat({24'h0, msg[i]}, 4'h1, i == 8, w);
        expect_result("bytewise", 32'hCBF43926, 16'd9, 1'b0);

        std_frame(0);
        expect_result("wordwise", 32'hCBF43926, 16'd9, 1'b0);

        beat(32'hDEADBEEF, 4'h0, 1'b1, w);
        expect_result("empty", 32'h00000000, 16'd0, 1'b0);

        // Sparse keeps plus an all-skipped middle beat
        beat(32'h32AA31BB, 4'b1010, 1'b0, w);
        beat(32'hFFFFFFFF, 4'b0000, 1'b0, w);
        beat(32'h36353433, 4'b1111, 1'b0, w);
        beat(32'h39CC3837, 4'b1011, 1'b1, w);
        expect_result("sparse", 32'hCBF43926, 16'd9, 1'b0);

        // Check mode; check_en drops after the first beat
        check_en = 1;
        beat(32'h34333231, 4'hF, 1'b0, w);
        check_en = 0;
        beat(32'h38373635, 4'hF, 1'b0, w);
        beat(32'hF4392639, 4'hF, 1'b0, w);
        beat(32'h000000CB, 4'h1, 1'b1, w);
        expect_result("check_good", 32'h2144DF1C ^ 32'hFFFFFFFF ^ 32'hFFFFFFFF,
                      16'd13, 1'b1);

        check_en = 1;
        beat(32'h34333231, 4'hF, 1'b0, w);
        check_en = 0;
        beat(32'h38373735, 4'hF, 1'b0, w);
        beat(32'hF4392639, 4'hF, 1'b0, w);
        beat(32'h000000CB, 4'h1, 1'b1, w);
        @(negedge clk);
        chk("check_bad_valid", {31'd0, crc_valid}, 32'd1);
        chk("check_bad_match", {31'd0, crc_match}, 32'd0);
        @(posedge clk);
        #1;

        // Abort after 5 bytes, beat offered during clr is refused
        n0 = nvalid;
        beat(32'h34333231, 4'hF, 1'b0, w);
        beat(32'h00000035, 4'h1, 1'b0, w);
        clr = 1; s_valid = 1; s_data = 32'h39; s_keep = 4'h1; s_last = 1;
        @(negedge clk);
        chk("clr_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk);
        #1;
        clr = 0; s_valid = 0;
        idle(2);
        std_frame(0);
        expect_result("after_clr", 32'hCBF43926, 16'd9, 1'b0);
        chk("clr_one_pulse", nvalid - n0, 32'd1);

        // Back-to-back frames: second frame's first beat stalls on DONE
        std_frame(0);
        beat(32'h34333231, 4'hF, 1'b0, w);
        chk("done_stall", w, 32'd1);
        beat(32'h38373635, 4'hF, 1'b0, w);
        beat(32'h00000039, 4'h1, 1'b1, w);
        expect_result("backpressure", 32'hCBF43926, 16'd9, 1'b0);

        for (int g = 0; g < 3; g++) begin
            std_frame(1);
            expect_result("gaps", 32'hCBF43926, 16'd9, 1'b0);
        end

        // Reset mid-frame
        beat(32'h34333231, 4'hF, 1'b0, w);
        rst = 1;
        idle(1);
        rst = 0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_mid_crc", crc_out, 32'h0);
        @(posedge clk);
        #1;
        std_frame(0);
        expect_result("after_rst", 32'hCBF43926, 16'd9, 1'b0);

        // Byte counter saturation (65600 bytes)
        for (int i = 0; i < 16399; i++)
            beat(32'(i * 32'h9E3779B1), 4'hF, 1'b0, w);
        beat(32'h01020304, 4'hF, 1'b1, w);
        @(negedge clk);
        chk("sat_valid", {31'd0, crc_valid}, 32'd1);
        chk("sat_cnt", {16'd0, byte_cnt}, 32'h0000FFFF);
        @(posedge clk);
        #1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_32_stream.md
Name: crc_32_stream

Overview:
Parametrised successor to the byte-serial CRC-32 engine. It computes the Ethernet CRC-32 (FCS) over a framed stream, DATA_BYTES bytes per beat, with partial-beat byte enables and a valid/ready handshake. It has two modes: generate (report the FCS) and check (the frame includes a received FCS; report pass/fail via residue compare). It sits between the MAC framing logic and the TX FCS inserter / RX frame filter.

Parameters:
DATA_BYTES, 4, bytes per beat; legal 1..8
POLY, 32'hEDB88320, reflected generator polynomial
INIT, 32'hFFFFFFFF, CRC register value at frame start
XOR_OUT, 32'hFFFFFFFF, final XOR applied to crc_out
RESIDUE, 32'hDEBB20E3, expected pre-XOR register after data+FCS in check mode
CNT_W, 16, width of the frame byte counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
clr  in  1  abort current frame and return to idle (synchronous)
check_en  in  1  mode select, sampled on first accepted beat of a frame; 1 = check
s_valid  in  1  beat valid
s_ready  out  1  engine can accept beat
s_data  in  8*DATA_BYTES  beat data; byte i = s_data[8i+7:8i], byte 0 first on wire
s_keep  in  DATA_BYTES  byte enables; keep[i]=0 means byte i is skipped
s_last  in  1  final beat of frame
crc_out  out  32  final CRC (register ^ XOR_OUT), reflected Ethernet convention
crc_valid  out  1  one-cycle pulse: crc_out/crc_match/byte_cnt are valid
crc_match  out  1  check mode: pre-XOR register == RESIDUE; 0 in generate mode
byte_cnt  out  CNT_W  kept bytes in the frame, saturating at all-ones

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. Reset values: state=IDLE, crc register=INIT, crc_out=0, crc_valid=0, crc_match=0, byte_cnt=0, and s_ready=0 while rst=1.
- Accept = s_valid & s_ready.
- s_ready = (state != DONE) & ~clr & ~rst, combinational.
- States:
  - IDLE: on accept, fold kept bytes into INIT and latch check_en. If s_last, go to DONE; else go to ACCUM.
  - ACCUM: on accept, fold kept bytes into the register. If s_last, go to DONE.
  - DONE (one cycle): register crc_out, crc_match and byte_cnt; pulse crc_valid; reload register=INIT; clear the byte counter. Go to IDLE.
- Latency: crc_valid asserts exactly 1 cycle after the s_last beat is accepted. Minimum throughput is one idle cycle per frame (the DONE cycle).
- Folding: kept bytes are applied in ascending index order, one byte step per kept byte. Use an unrolled combinational chain within the cycle; there is no contiguity requirement on keep.
- keep=0 on a non-last beat leaves the register unchanged.
- A last beat with keep=0 ends the frame with no data in that beat.
- An empty frame (single last beat, keep=0) gives crc_out = INIT^XOR_OUT = 32'h00000000 and byte_cnt=0.
- byte_cnt accumulates the popcount of keep per accepted beat and saturates; it does not wrap.
- s_valid gaps mid-frame: the register is held; no effect on the result.
- crc_out, crc_match and byte_cnt hold their value until the next DONE. crc_valid is low otherwise.
- clr in any state: go to IDLE, register=INIT, counter=0, no crc_valid pulse. A beat presented in the same cycle is not accepted (s_ready=0).
- clr in DONE: the DONE outputs are still registered and pulsed (the frame was complete); the state then goes to IDLE.
- rst has priority over clr. Mid-frame rst discards the frame.
- check_en changes after the first beat have no effect until the next frame.

Decomposition:
- Package crc_32_stream_pkg holds:
  - constants CRC32_POLY, CRC32_INIT, CRC32_XOR_OUT, CRC32_RESIDUE;
  - typedef state_t (IDLE, ACCUM, DONE);
  - function crc32_byte(crc, byte, poly) for one reflected byte step.
- One sub-module crc_32_fold: purely combinational. It takes the register, s_data and s_keep and returns the next register via a DATA_BYTES-long chain of crc32_byte. This keeps the FSM/handshake module separate from the arithmetic.

Test Plan:
- DATA_BYTES=1, ASCII "123456789" (31..39), keep=1, last on 39 -> crc_valid 1 cycle after the last accept, crc_out=32'hCBF43926, byte_cnt=9, crc_match=0.
- DATA_BYTES=4, beats 32'h34333231, 32'h38373635, then 32'h00000039 with keep=4'b0001 and last -> crc_out=32'hCBF43926, byte_cnt=9. Empty frame (last, keep=0) -> crc_out=32'h00000000.
- Check mode, "123456789" followed by 26 39 F4 CB -> crc_match=1, byte_cnt=13. Flip one bit of byte 5 -> crc_match=0.
- clr after 5 bytes, then the full "123456789" frame -> exactly one crc_valid, crc_out=32'hCBF43926. clr with a simultaneous s_valid -> beat not accepted.
- Backpressure: s_valid held high across DONE -> s_ready=0 that cycle and the beat is accepted the next cycle; the next frame's result is still correct. Random s_valid gaps mid-frame -> same crc_out.
- rst pulsed mid-frame -> all outputs at reset values next cycle, s_ready=1 the cycle after rst drops; the next frame gives the correct CRC.
